block_interleaver_pp: RTL and testbench

Parametrised ping-pong block interleaver/deinterleaver for the encoder/decoder datapath. Accepts an AXI-Stream-like word stream, buffers NUM_CW codewords of CW_LEN words per block in one of two banks, and emits the block transposed. The per-block mode selects interleave (codeword-major in, column-major out) or deinterleave (column-major in, codeword-major out). One bank fills while the other drains, sustaining 1 word/cycle when both sides are ready.

---
 rtl/block_interleaver_pp_if.sv | 17 +
 rtl/block_interleaver_pp.sv | 212 +++++++++++++++++++++
 tb/tb_block_interleaver_pp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/block_interleaver_pp_if.sv
// Word-stream handshake bundle used on both the input and output sides of block_interleaver_pp.
// The input-side tlast is only consumed when INTLV_FRAME_CHECK_EN is defined.
interface block_interleaver_pp_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
`ifdef INTLV_FRAME_CHECK_EN
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`else
    modport slave  (input tdata, input tvalid, output tready);
`endif
endinterface

// File: rtl/block_interleaver_pp.sv
// Ping-pong block interleaver/deinterleaver: one bank fills while the other drains transposed.
// Optional INTLV_FRAME_CHECK_EN adds s_axis.tlast checking and the err_frame pulse output.
module block_interleaver_pp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CW_LEN = 65,
    parameter int unsigned NUM_CW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    block_interleaver_pp_if.slave  s_axis,
    block_interleaver_pp_if.master m_axis
`ifdef INTLV_FRAME_CHECK_EN
    ,
    output logic                   err_frame
`endif
);
    localparam int unsigned BLK  = NUM_CW * CW_LEN;
    localparam int unsigned AW   = $clog2(2 * BLK);
    localparam int unsigned CNTW = $clog2(BLK);
    localparam int unsigned RW   = $clog2(NUM_CW);
    localparam int unsigned CLW  = $clog2(CW_LEN);

    typedef enum logic {IDLE, RUN} rd_state_t;

    logic [DATA_W-1:0] mem [2*BLK];

    logic [RW-1:0]     wr_row, rd_row;
    logic [CLW-1:0]    wr_col, rd_col;
    logic [CNTW-1:0]   wr_cnt, rd_cnt;
    logic              wr_bank, rd_bank, wr_bank_n;
    logic [1:0]        bank_full, bank_full_n, bank_mode;
    logic              s_ready;
    rd_state_t         state, state_n;
    logic              rd_pend, rd_last_q;
    logic [DATA_W-1:0] ram_q;
    logic              m_valid, m_last, sk_valid, sk_last;
    logic [DATA_W-1:0] m_data, sk_data;
    logic              wr_fire_c, wr_last_c, wr_mode_c;
    logic              rd_issue_c, rd_last_c, pop_c, space_c;
    logic [1:0]        occ_c;
    logic [RW+CLW-1:0] wr_step_c, rd_step_c;
    logic [AW-1:0]     wr_addr_c, rd_addr_c;

    // Advance a (row, col) position with either row or col as the fastest-moving index.
    function automatic logic [RW+CLW-1:0] step_pos(input logic [RW-1:0] row,
                                                   input logic [CLW-1:0] col,
                                                   input logic row_fast);
        logic [RW-1:0]  r;
        logic [CLW-1:0] c;
        r = row;
        c = col;
        if (row_fast) begin
            if (row == RW'(NUM_CW - 1)) begin
                r = '0;
                c = col + CLW'(1);
            end else begin
                r = row + RW'(1);
            end
        end else begin
            if (col == CLW'(CW_LEN - 1)) begin
                c = '0;
                r = row + RW'(1);
            end else begin
                c = col + CLW'(1);
            end
        end
        return {r, c};
    endfunction

    assign wr_fire_c = s_axis.tvalid && s_ready;
    assign wr_last_c = (wr_cnt == CNTW'(BLK - 1));
    assign wr_mode_c = (wr_cnt == '0) ? mode : bank_mode[wr_bank];
    assign wr_step_c = step_pos(wr_row, wr_col, wr_mode_c);
    assign wr_addr_c = AW'(wr_bank) * AW'(BLK) + AW'(wr_row) * AW'(CW_LEN) + AW'(wr_col);

    assign rd_last_c = (rd_cnt == CNTW'(BLK - 1));
    assign rd_step_c = step_pos(rd_row, rd_col, !bank_mode[rd_bank]);
    assign rd_addr_c = AW'(rd_bank) * AW'(BLK) + AW'(rd_row) * AW'(CW_LEN) + AW'(rd_col);

    // Reads in flight plus buffered words never exceed the two output slots.
    assign pop_c   = m_valid && m_axis.tready;
    assign occ_c   = 2'(m_valid) + 2'(sk_valid) + 2'(rd_pend);
    assign space_c = (occ_c != 2'd2) || pop_c;

    always_comb begin
        bank_full_n = bank_full;
        if (wr_fire_c && wr_last_c) bank_full_n[wr_bank] = 1'b1;
        if (rd_issue_c && rd_last_c) bank_full_n[rd_bank] = 1'b0;
        wr_bank_n = wr_bank ^ (wr_fire_c && wr_last_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_row    <= '0;
            wr_col    <= '0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_mode <= '0;
            bank_full <= '0;
            s_ready   <= 1'b0;
        end else begin
            bank_full <= bank_full_n;
            wr_bank   <= wr_bank_n;
            s_ready   <= !bank_full_n[wr_bank_n];
            if (wr_fire_c) begin
                if (wr_cnt == '0) bank_mode[wr_bank] <= mode;
                if (wr_last_c) begin
                    wr_row <= '0;
                    wr_col <= '0;
                    wr_cnt <= '0;
                end else begin
                    {wr_row, wr_col} <= wr_step_c;
                    wr_cnt           <= wr_cnt + CNTW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire_c) mem[wr_addr_c] <= s_axis.tdata;
        if (rd_issue_c) ram_q <= mem[rd_addr_c];
    end

    // Read FSM: IDLE starts a full bank immediately, so bank changes cost no bubble.
    always_comb begin
        state_n    = state;
        rd_issue_c = 1'b0;
        case (state)
            IDLE: begin
                if (bank_full[rd_bank] && space_c) begin
                    rd_issue_c = 1'b1;
                    state_n    = RUN;
                end
            end
            RUN: begin
                if (space_c) rd_issue_c = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (rd_issue_c && rd_last_c) state_n = bank_full[!rd_bank] ? RUN : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_row    <= '0;
            rd_col    <= '0;
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            rd_pend   <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state   <= state_n;
            rd_pend <= rd_issue_c;
            if (rd_issue_c) begin
                rd_last_q <= rd_last_c;
                if (rd_last_c) begin
                    rd_row  <= '0;
                    rd_col  <= '0;
                    rd_cnt  <= '0;
                    rd_bank <= !rd_bank;
                end else begin
                    {rd_row, rd_col} <= rd_step_c;
                    rd_cnt           <= rd_cnt + CNTW'(1);
                end
            end
        end
    end

    // Two-entry output buffer: head drives the port, skid absorbs the word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= '0;
            sk_valid <= 1'b0;
            sk_last  <= 1'b0;
            sk_data  <= '0;
        end else if (!m_valid || pop_c) begin
            if (sk_valid) begin
                m_valid  <= 1'b1;
                m_data   <= sk_data;
                m_last   <= sk_last;
                sk_valid <= rd_pend;
                sk_data  <= ram_q;
                sk_last  <= rd_last_q;
            end else begin
                m_valid <= rd_pend;
                m_last  <= rd_pend && rd_last_q;
                if (rd_pend) m_data <= ram_q;
            end
        end else if (rd_pend) begin
            sk_valid <= 1'b1;
            sk_data  <= ram_q;
            sk_last  <= rd_last_q;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = m_last;
    assign m_axis.tdata  = m_data;

`ifdef INTLV_FRAME_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_frame <= 1'b0;
        else     err_frame <= wr_fire_c && (s_axis.tlast != wr_last_c);
    end
`endif

endmodule

// File: tb/tb_block_interleaver_pp.sv
// Directed + randomized bench for block_interleaver_pp against a matrix-transpose reference model.
module tb_block_interleaver_pp;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CW_LEN = 3;
    localparam int unsigned NUM_CW = 4;
    localparam int unsigned BLK    = NUM_CW * CW_LEN;
    localparam int          NB     = int'(BLK);
    localparam int          NR     = int'(NUM_CW);
    localparam int          NC     = int'(CW_LEN);

    typedef struct packed {
        logic              m;
        logic              tl;
        logic              e;
        logic [DATA_W-1:0] d;
    } word_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic mode = 1'b0;

    block_interleaver_pp_if #(.DATA_W(DATA_W)) s_axis ();
    block_interleaver_pp_if #(.DATA_W(DATA_W)) m_axis ();
`ifdef INTLV_FRAME_CHECK_EN
    logic err_frame;
`endif

    block_interleaver_pp #(.DATA_W(DATA_W), .CW_LEN(CW_LEN), .NUM_CW(NUM_CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .s_axis    (s_axis),
        .m_axis    (m_axis)
`ifdef INTLV_FRAME_CHECK_EN
        ,
        .err_frame (err_frame)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int in_acc = 0;
    int t_acc = -1;
    int first_v = -1;
    int gaps = 0;
    int n_out = 0;
    int err_cnt = 0;
    bit track_gap = 1'b0;
    bit stalled = 1'b0;
    logic [DATA_W:0] held = '0;
    word_t           in_q[$];
    logic [DATA_W:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Queue one block for sending and append its transposed image to the expected stream.
    task automatic add_block(input logic m, input logic [DATA_W-1:0] src [BLK], input int bad_tl);
        logic [DATA_W-1:0] mat [NUM_CW][CW_LEN];
        word_t w;
        for (int i = 0; i < NB; i++) begin
            w.m  = m;
            w.d  = src[i];
            w.e  = (i == NB - 1);
            w.tl = (i == NB - 1) || (i == bad_tl);
            in_q.push_back(w);
            if (!m) mat[i / NC][i % NC] = src[i];
            else    mat[i % NR][i / NR] = src[i];
        end
        if (!m) begin
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++)
                    exp_q.push_back({(r == NR - 1) && (c == NC - 1), mat[r][c]});
        end else begin
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < NC; c++)
                    exp_q.push_back({(r == NR - 1) && (c == NC - 1), mat[r][c]});
        end
    endtask

    // One clock: drive at the falling edge, observe 1 time unit later, advance.
    task automatic step(input int rdy_pct);
        m_axis.tready = (int'($urandom_range(99)) < rdy_pct);
        if (in_q.size() > 0) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = in_q[0].d;
            s_axis.tlast  = in_q[0].tl;
            mode          = in_q[0].m;
        end else begin
            s_axis.tvalid = 1'b0;
            s_axis.tlast  = 1'b0;
        end
        #1;
        if (stalled)
            check("hold", 64'({m_axis.tvalid, m_axis.tlast, m_axis.tdata}), 64'({1'b1, held}));
        if (m_axis.tvalid && first_v < 0) first_v = cyc;
        if (track_gap && n_out > 0 && !m_axis.tvalid && exp_q.size() > 0) gaps++;
        if (m_axis.tvalid && m_axis.tready) begin
            n_out++;
            n_chk++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_word: observed 0x%0h expected no output", m_axis.tdata);
            end
            if (exp_q.size() != 0)
                check("out_word", 64'({m_axis.tlast, m_axis.tdata}), 64'(exp_q.pop_front()));
        end
        stalled = m_axis.tvalid && !m_axis.tready;
        held    = {m_axis.tlast, m_axis.tdata};
`ifdef INTLV_FRAME_CHECK_EN
        if (err_frame) err_cnt++;
`endif
        if (s_axis.tvalid && s_axis.tready) begin
            if (in_q[0].e) t_acc = cyc;
            void'(in_q.pop_front());
            in_acc++;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int rdy_pct, input int limit, input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || in_q.size() != 0) && k < limit) begin
            step(rdy_pct);
            k++;
        end
        check(tag, 64'(exp_q.size() + in_q.size()), 64'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] src [BLK];
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_tready", 64'(s_axis.tready), 64'(0));
        check("rst_tvalid", 64'(m_axis.tvalid), 64'(0));
        check("rst_tlast",  64'(m_axis.tlast),  64'(0));
        check("rst_tdata",  64'(m_axis.tdata),  64'(0));
        rst = 1'b0;
        #1;
        check("tready_before_edge", 64'(s_axis.tready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("tready_after_edge", 64'(s_axis.tready), 64'(1));

        // Interleave 0..11, with first-output latency
        for (int i = 0; i < NB; i++) src[i] = DATA_W'(i);
        add_block(1'b0, src, -1);
        first_v = -1;
        t_acc   = -1;
        drain(100, 200, "t1_drain");
        check("latency", 64'(first_v - t_acc), 64'(3));

        // Deinterleave the column-major image back to 0..11
        for (int k = 0; k < NB; k++) src[k] = DATA_W'((k % NR) * NC + k / NR);
        add_block(1'b1, src, -1);
        drain(100, 200, "t2_drain");

        // Three blocks into a stalled output: the third must wait
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < NB; i++) src[i] = $urandom;
            add_block(1'b0, src, -1);
        end
        in_acc = 0;
        repeat (40) step(0);
        check("bp_accepted", 64'(in_acc), 64'(2 * NB));
        check("bp_tready", 64'(s_axis.tready), 64'(0));
        n_out     = 0;
        gaps      = 0;
        track_gap = 1'b1;
        drain(100, 200, "t3_drain");
        track_gap = 1'b0;
        check("t3_gaps",  64'(gaps),  64'(0));
        check("t3_count", 64'(n_out), 64'(3 * NB));

        // Ten random blocks, alternating modes, random output backpressure
        for (int b = 0; b < 10; b++) begin
            for (int i = 0; i < NB; i++) src[i] = $urandom;
            add_block(1'(b % 2), src, -1);
        end
        drain(50, 3000, "t4_drain");

        // Reset part-way through the second block, then a fresh block
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NB; i++) src[i] = $urandom;
            add_block(1'(b), src, -1);
        end
        in_acc = 0;
        for (int k = 0; k < 200 && in_acc < NB + 7; k++) step(0);
        check("t5_accepted", 64'(in_acc), 64'(NB + 7));
        rst     = 1'b1;
        stalled = 1'b0;
        in_q.delete();
        exp_q.delete();
        repeat (3) step(100);
        check("t5_rst_valid", 64'(m_axis.tvalid), 64'(0));
        rst = 1'b0;
        repeat (4) step(100);
        check("t5_idle_valid", 64'(m_axis.tvalid), 64'(0));
        for (int i = 0; i < NB; i++) src[i] = $urandom;
        add_block(1'b0, src, -1);
        drain(100, 200, "t5_drain");
        repeat (20) step(100);

`ifdef INTLV_FRAME_CHECK_EN
        // Early tlast on word 10: one error pulse, data unaffected
        for (int i = 0; i < NB; i++) src[i] = $urandom;
        err_cnt = 0;
        add_block(1'b0, src, 9);
        drain(100, 200, "t6_drain");
        repeat (4) step(100);
        check("err_pulses", 64'(err_cnt), 64'(1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
